// File: rtl/spm_arbiter.sv
// Two-requester round-robin front end for a serial-parallel multiplier.
// Grants one operand pair at a time, sequences the multiplier and returns the product or a timeout error.
module spm_arbiter #(
    parameter int W       = 8,
    parameter int TIMEOUT = 40
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [W-1:0]   req0_x,
    input  logic [W-1:0]   req0_y,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [W-1:0]   req1_x,
    input  logic [W-1:0]   req1_y,
    output logic           resp_valid,
    input  logic           resp_ready,
    output logic           resp_id,
    output logic [2*W-1:0] resp_prod,
    output logic           resp_err,
    output logic           spm_rst,
    output logic [W-1:0]   spm_x,
    output logic [W-1:0]   spm_y,
    input  logic           spm_done,
    input  logic [2*W-1:0] spm_prod,
    output logic           busy
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        RESP
    } state_t;

    state_t         state_q;
    logic           last_grant_q;
    logic [W-1:0]   x_q;
    logic [W-1:0]   y_q;
    logic           id_q;
    logic [CW-1:0]  cnt_q;
    logic [2*W-1:0] resp_prod_q;
    logic           resp_id_q;
    logic           resp_err_q;
    logic           resp_valid_q;
    logic           spm_rst_q;
    logic           busy_q;

    logic gnt0;
    logic gnt1;
    logic idle_ok;

    // On a tie the requester that did not win last time is favoured.
    always_comb begin
        gnt0       = req0_valid & (~req1_valid | last_grant_q);
        gnt1       = req1_valid & (~req0_valid | ~last_grant_q);
        idle_ok    = rst & (state_q == IDLE);
        req0_ready = idle_ok & gnt0;
        req1_ready = idle_ok & gnt1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            x_q          <= '0;
            y_q          <= '0;
            id_q         <= 1'b0;
            cnt_q        <= '0;
            resp_prod_q  <= '0;
            resp_id_q    <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            spm_rst_q    <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req0_ready | req1_ready) begin
                        x_q     <= req0_ready ? req0_x : req1_x;
                        y_q     <= req0_ready ? req0_y : req1_y;
                        id_q    <= req1_ready;
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    cnt_q     <= '0;
                    spm_rst_q <= 1'b0;
                    state_q   <= RUN;
                end
                RUN: begin
                    // Completion takes priority over a timeout landing on the same cycle.
                    if (spm_done) begin
                        resp_prod_q  <= spm_prod;
                        resp_err_q   <= 1'b0;
                        resp_id_q    <= id_q;
                        resp_valid_q <= 1'b1;
                        spm_rst_q    <= 1'b1;
                        state_q      <= RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        resp_prod_q  <= '0;
                        resp_err_q   <= 1'b1;
                        resp_id_q    <= id_q;
                        resp_valid_q <= 1'b1;
                        spm_rst_q    <= 1'b1;
                        state_q      <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        last_grant_q <= resp_id_q;
                        resp_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_prod  = resp_prod_q;
    assign resp_err   = resp_err_q;
    assign spm_rst    = spm_rst_q;
    assign spm_x      = x_q;
    assign spm_y      = y_q;
    assign busy       = busy_q;

endmodule

// File: doc/spm_arbiter.md
SPM_ARBITER -- requirements
Module: spm_arbiter

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the operand width; products are 2*W bits.
REQ-002 The block SHALL have parameter TIMEOUT, default 40, giving the maximum RUN cycles to wait for spm_done.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst, input, 1, reset, synchronous and active-low.
REQ-005 The block SHALL have ports req0_valid / req1_valid, input, 1, requester N presents operands.
REQ-006 The block SHALL have ports req0_ready / req1_ready, output, 1, operand accept for requester N.
REQ-007 The block SHALL have ports req0_x, req0_y, req1_x, req1_y, input, W, multiplicand and multiplier per requester.
REQ-008 The block SHALL have port resp_valid, output, 1, result available.
REQ-009 The block SHALL have port resp_ready, input, 1, consumer accepts result.
REQ-010 The block SHALL have port resp_id, output, 1, requester that owns the result.
REQ-011 The block SHALL have port resp_prod, output, 2*W, product.
REQ-012 The block SHALL have port resp_err, output, 1, timeout flag.
REQ-013 The block SHALL have port spm_rst, output, 1, active-high reset/start for the serial-parallel multiplier.
REQ-014 The block SHALL have ports spm_x and spm_y, output, W, operands driven to the multiplier.
REQ-015 The block SHALL have port spm_done, input, 1, multiplier completion.
REQ-016 The block SHALL have port spm_prod, input, 2*W, multiplier product (fullprod).
REQ-017 The block SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-018 The block SHALL implement the FSM IDLE -> LOAD -> RUN -> RESP -> IDLE.
REQ-019 IDLE: assert spm_rst=1; when any reqN_valid=1, assert ready to exactly one granted requester, combinationally, in the same cycle.
REQ-020 Grant rule: only one valid requester wins; if both are valid, the requester other than last_grant wins. last_grant resets to 1, so req0 wins first.
REQ-021 On the accept cycle (valid&ready), the block SHALL latch x, y and the id into internal registers and move to LOAD.
REQ-022 The block SHALL never accept more than one request at a time.
REQ-023 reqN_ready SHALL be 0 in every state other than IDLE.
REQ-024 LOAD (exactly 1 cycle): spm_x/spm_y = latched operands, spm_rst=1; next state RUN.
REQ-025 RUN: spm_rst=0, spm_x/spm_y held stable, cycle counter increments from 0.
REQ-026 In RUN, spm_done=1 SHALL capture spm_prod into resp_prod, set resp_err=0 and move to RESP.
REQ-027 When the counter reaches TIMEOUT-1 with spm_done=0, the block SHALL set resp_prod=0, set resp_err=1 and move to RESP.
REQ-028 If spm_done=1 on the timeout cycle, done SHALL win.
REQ-029 RESP: resp_valid=1 and spm_rst=1; resp_prod, resp_id and resp_err SHALL be held stable until resp_ready=1.
REQ-030 On the resp handshake, the block SHALL update last_grant=resp_id, deassert resp_valid the next cycle and return to IDLE.
REQ-031 A new request SHALL be accepted no earlier than the cycle after the handshake.
REQ-032 Latency: accept at edge T, LOAD in T+1, RUN from T+2; resp_valid SHALL rise the cycle after spm_done is sampled.
REQ-033 Fairness: with both requesters continuously valid, grants SHALL alternate 0,1,0,1.
REQ-034 Requesters SHALL hold x/y stable while valid=1 and ready=0; the block SHALL never drop a pending valid.
REQ-035 The resp_id/resp_prod/resp_err registers SHALL be held at their last value after the handshake until the next RESP.

Reset
REQ-036 When rst=0 at a clock edge, regardless of state, the block SHALL enter IDLE, clear the counter and operand registers, and set last_grant=1.
REQ-037 Reset values: req0_ready=req1_ready=0 during reset, resp_valid=0, resp_id=0, resp_prod=0, resp_err=0, spm_rst=1, spm_x=spm_y=0, busy=0.
REQ-038 Reset mid-operation SHALL discard the in-flight request with no response.

Verification
REQ-039 Single request: req0 x=13, y=39; multiplier model done after 16 cycles -> resp_valid with resp_prod=507, resp_id=0, resp_err=0; exactly one accept.
REQ-040 Simultaneous requests after reset: req0 (255,255) and req1 (0,7) -> first response id=0 with prod=65025, second id=1 with prod=0; req1_ready=0 until the first handshake.
REQ-041 Back-pressure: resp_ready=0 for 5 cycles -> resp_valid=1 and prod/id/err unchanged each cycle, busy=1, no reqN_ready asserted.
REQ-042 Timeout: spm_done tied 0, req1 (3,4) -> resp_valid exactly TIMEOUT RUN cycles after LOAD, with resp_err=1, resp_prod=0, resp_id=1; then IDLE.
REQ-043 Reset in RUN: rst=0 for one edge -> next cycle all outputs at reset values, spm_rst=1, no response; a following req0 (2,3) returns prod=6.
REQ-044 Round-robin: both requesters continuously valid for 4 transactions -> resp_id sequence 0,1,0,1 with correct products.
